record_packer: RTL and testbench

- Sits directly downstream of the virtual merge-sorter tree.
- Consumes the tree's sorted stream of one DATW-bit record per cycle.
- Packs 2^P_LOG consecutive records into one wide word, buffers packed words in a small output FIFO, and presents them to the write-back side with a valid/ready handshake.
- Generates the tree's stall input (IN_FULL) so that no record is lost under back-pressure.

---
 rtl/record_packer_pkg.sv | 25 ++
 rtl/packer_ofifo.sv | 50 +++++
 rtl/record_packer.sv | 115 +++++++++++
 tb/tb_record_packer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/record_packer_pkg.sv
// Shared definitions for the record packer and the merge-sorter tree:
// record/key macros, pad value, FIFO depth and stall threshold helpers.
`ifndef RECORD_PACKER_PKG_MACROS
`define RECORD_PACKER_PKG_MACROS
`define RP_WORD_W(datw, p_log) ((datw) << (p_log))
`define RP_KEY(rec, keyw) rec[(keyw)-1:0]
`define RP_PAD_REC(w) {(w){1'b1}}
`endif

package record_packer_pkg;

    function automatic int unsigned fifo_depth(input int unsigned log_depth);
        return 32'd1 << log_depth;
    endfunction

    // One word of headroom absorbs the records already in flight when IN_FULL rises.
    function automatic int unsigned in_full_th(input int unsigned log_depth);
        return fifo_depth(log_depth) - 32'd1;
    endfunction

    localparam int unsigned OFIFO_LOG_DEF   = 2;
    localparam int unsigned OFIFO_DEPTH_DEF = fifo_depth(OFIFO_LOG_DEF);
    localparam int unsigned IN_FULL_TH_DEF  = in_full_th(OFIFO_LOG_DEF);

endpackage

// File: rtl/packer_ofifo.sv
// Generic first-word-fall-through FIFO with occupancy count; a write into a
// full FIFO is accepted only when a read retires the head in the same cycle.
module packer_ofifo
    import record_packer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LOG   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic [LOG:0]     cnt,
    output logic [LOG:0]     cnt_nxt,
    output logic             ovf
);
    localparam int unsigned DEPTH = fifo_depth(LOG);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LOG-1:0]   rptr, wptr;
    logic             do_rd, do_wr;

    always_comb begin
        valid   = (cnt != '0);
        do_rd   = rd_en && valid;
        do_wr   = wr_en && ((cnt != (LOG+1)'(DEPTH)) || do_rd);
        ovf     = wr_en && !do_wr;
        cnt_nxt = cnt + (LOG+1)'(do_wr) - (LOG+1)'(do_rd);
        rd_data = valid ? mem[rptr] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            rptr <= '0;
            wptr <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (do_rd) rptr <= rptr + 1'b1;
            if (do_wr) wptr <= wptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= wr_data;
    end
endmodule

// File: rtl/record_packer.sv
// Packs 2^P_LOG sorted records per wide word into an output FIFO and stalls the tree.
// Define RECORD_PACKER_ORDER_CHECK_EN to add the ERR_ORD key-order monitor.
module record_packer
    import record_packer_pkg::*;
#(
    parameter int unsigned P_LOG     = 3,
    parameter int unsigned DATW      = 64,
    parameter int unsigned KEYW      = 32,
    parameter int unsigned OFIFO_LOG = 2
) (
    input  logic                         CLK,
    input  logic                         RST_X,
    input  logic [DATW-1:0]              DIN,
    input  logic                         DINEN,
    input  logic                         FLUSH,
    output logic                         IN_FULL,
    output logic [`RP_WORD_W(DATW, P_LOG)-1:0] DOT,
    output logic [P_LOG:0]               DOT_CNT,
    output logic                         DOTEN,
    input  logic                         DOT_RDY,
    output logic                         ERR_OVF
`ifdef RECORD_PACKER_ORDER_CHECK_EN
    ,
    output logic                         ERR_ORD
`endif
);
    localparam int unsigned NREC  = 1 << P_LOG;
    localparam int unsigned WORDW = `RP_WORD_W(DATW, P_LOG);
    localparam int unsigned ENTW  = WORDW + P_LOG + 1;

    if (KEYW > DATW) begin : g_bad_keyw
        $error("KEYW must not exceed DATW");
    end

    logic [DATW-1:0]  acc [NREC];
    logic [P_LOG-1:0] idx;
    logic [P_LOG:0]   fill_cnt;
    logic [WORDW-1:0] push_word;
    logic             push, pop, ovf;
    logic [ENTW-1:0]  head;
    logic [OFIFO_LOG:0] f_cnt, f_cnt_nxt;

    // The incoming record is merged into the pushed word so a completing or
    // flushing record never waits a cycle in the accumulator.
    always_comb begin
        fill_cnt  = {1'b0, idx} + (P_LOG+1)'(DINEN);
        push      = (DINEN && (idx == '1)) || (FLUSH && (fill_cnt != '0));
        push_word = '0;
        for (int unsigned k = 0; k < NREC; k++) begin
            if (P_LOG'(k) < idx)
                push_word[DATW*k +: DATW] = acc[k];
            else if (DINEN && (P_LOG'(k) == idx))
                push_word[DATW*k +: DATW] = DIN;
            else
                push_word[DATW*k +: DATW] = `RP_PAD_REC(DATW);
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X)     idx <= '0;
        else if (push)  idx <= '0;
        else if (DINEN) idx <= idx + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (DINEN) acc[idx] <= DIN;
    end

    packer_ofifo #(.WIDTH(ENTW), .LOG(OFIFO_LOG)) u_ofifo (
        .clk     (CLK),
        .rst_n   (RST_X),
        .wr_en   (push),
        .wr_data ({fill_cnt, push_word}),
        .rd_en   (pop),
        .rd_data (head),
        .valid   (DOTEN),
        .cnt     (f_cnt),
        .cnt_nxt (f_cnt_nxt),
        .ovf     (ovf)
    );

    assign pop     = DOTEN && DOT_RDY;
    assign DOT     = head[WORDW-1:0];
    assign DOT_CNT = head[ENTW-1:WORDW];

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            IN_FULL <= 1'b0;
            ERR_OVF <= 1'b0;
        end else begin
            IN_FULL <= ({1'b0, f_cnt_nxt} >= (OFIFO_LOG+2)'(in_full_th(OFIFO_LOG)));
            ERR_OVF <= ERR_OVF | ovf;
        end
    end

`ifdef RECORD_PACKER_ORDER_CHECK_EN
    logic [KEYW-1:0] last_key;
    logic            key_vld;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            ERR_ORD  <= 1'b0;
            last_key <= '0;
            key_vld  <= 1'b0;
        end else begin
            if (DINEN) begin
                if (key_vld && (`RP_KEY(DIN, KEYW) < last_key)) ERR_ORD <= 1'b1;
                last_key <= `RP_KEY(DIN, KEYW);
                key_vld  <= 1'b1;
            end
            if (FLUSH) key_vld <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_record_packer.sv
// Directed self-checking bench for record_packer (default parameters).
module tb_record_packer;
    logic         CLK = 1'b0;
    logic         RST_X = 1'b0;
    logic [63:0]  DIN = '0;
    logic         DINEN = 1'b0;
    logic         FLUSH = 1'b0;
    logic         IN_FULL;
    logic [511:0] DOT;
    logic [3:0]   DOT_CNT;
    logic         DOTEN;
    logic         DOT_RDY = 1'b0;
    logic         ERR_OVF;
`ifdef RECORD_PACKER_ORDER_CHECK_EN
    logic         ERR_ORD;
`endif

    int checks = 0;
    int errors = 0;

    record_packer #(.P_LOG(3), .DATW(64), .KEYW(32), .OFIFO_LOG(2)) dut (
        .CLK     (CLK),
        .RST_X   (RST_X),
        .DIN     (DIN),
        .DINEN   (DINEN),
        .FLUSH   (FLUSH),
        .IN_FULL (IN_FULL),
        .DOT     (DOT),
        .DOT_CNT (DOT_CNT),
        .DOTEN   (DOTEN),
        .DOT_RDY (DOT_RDY),
        .ERR_OVF (ERR_OVF)
`ifdef RECORD_PACKER_ORDER_CHECK_EN
        ,
        .ERR_ORD (ERR_ORD)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] rec(input int unsigned k);
        return {32'hC0DE0000 + k, k};
    endfunction

    function automatic logic [511:0] word(input int unsigned first, input int unsigned n);
        logic [511:0] w;
        for (int unsigned k = 0; k < 8; k++)
            w[64*k +: 64] = (k < n) ? rec(first + k) : 64'hFFFF_FFFF_FFFF_FFFF;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_n(input int unsigned first, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            DIN   = rec(first + i);
            DINEN = 1'b1;
            tick();
        end
        DINEN = 1'b0;
    endtask

    task automatic pulse_reset();
        RST_X = 1'b0;
        tick();
        RST_X = 1'b1;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_doten", DOTEN, 0);
        chk("rst_in_full", IN_FULL, 0);
        chk("rst_err_ovf", ERR_OVF, 0);
        chk("rst_dot", DOT, 0);
        chk("rst_dot_cnt", DOT_CNT, 0);
        RST_X = 1'b1;
        tick();

        // streaming: keys 1..16 with consumer always ready
        DOT_RDY = 1'b1;
        send_n(1, 7);
        DIN = rec(8);
        DINEN = 1'b1;
        chk("stream_pre_doten", DOTEN, 0);
        tick();
        chk("stream_w0_doten", DOTEN, 1);
        chk("stream_w0_dot", DOT, word(1, 8));
        chk("stream_w0_cnt", DOT_CNT, 8);
        send_n(9, 8);
        chk("stream_w1_doten", DOTEN, 1);
        chk("stream_w1_dot", DOT, word(9, 8));
        chk("stream_w1_cnt", DOT_CNT, 8);
        tick();
        chk("stream_drained", DOTEN, 0);

        // partial flush of keys 5,6,7
        DOT_RDY = 1'b0;
        send_n(5, 3);
        chk("flush_pre_doten", DOTEN, 0);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        chk("flush_doten", DOTEN, 1);
        chk("flush_cnt", DOT_CNT, 3);
        chk("flush_dot", DOT, word(5, 3));
        DOT_RDY = 1'b1;
        tick();
        DOT_RDY = 1'b0;
        chk("flush_popped", DOTEN, 0);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        chk("flush_idle_noop", DOTEN, 0);
        tick();
        chk("flush_idle_noop2", DOTEN, 0);

        // back-pressure: 32 records, consumer stalled
        send_n(101, 16);
        chk("bp_in_full_2w", IN_FULL, 0);
        send_n(117, 8);
        chk("bp_in_full_3w", IN_FULL, 1);
        send_n(125, 8);
        chk("bp_in_full_4w", IN_FULL, 1);
        chk("bp_err_ovf", ERR_OVF, 0);
        chk("bp_dot_stable", DOT, word(101, 8));
        DOT_RDY = 1'b1;
        chk("bp_drain0", DOT, word(101, 8));
        tick();
        chk("bp_in_full_cnt3", IN_FULL, 1);
        chk("bp_drain1", DOT, word(109, 8));
        tick();
        chk("bp_in_full_cnt2", IN_FULL, 0);
        chk("bp_drain2", DOT, word(117, 8));
        tick();
        chk("bp_drain3", DOT, word(125, 8));
        tick();
        DOT_RDY = 1'b0;
        chk("bp_empty", DOTEN, 0);

        // simultaneous push and pop on a full FIFO
        send_n(201, 32);
        send_n(233, 7);
        DIN = rec(240);
        DINEN = 1'b1;
        DOT_RDY = 1'b1;
        tick();
        DINEN = 1'b0;
        DOT_RDY = 1'b0;
        chk("sim_no_ovf", ERR_OVF, 0);
        chk("sim_in_full", IN_FULL, 1);
        DOT_RDY = 1'b1;
        for (int unsigned j = 0; j < 4; j++) begin
            chk("sim_drain", DOT, word(209 + 8 * j, 8));
            tick();
        end
        DOT_RDY = 1'b0;
        chk("sim_empty", DOTEN, 0);

        // overflow: ignore IN_FULL, 40 records with consumer stalled
        send_n(301, 32);
        chk("ovf_pre", ERR_OVF, 0);
        send_n(333, 8);
        chk("ovf_set", ERR_OVF, 1);
        DOT_RDY = 1'b1;
        for (int unsigned j = 0; j < 4; j++) begin
            chk("ovf_drain", DOT, word(301 + 8 * j, 8));
            tick();
        end
        DOT_RDY = 1'b0;
        chk("ovf_empty", DOTEN, 0);
        chk("ovf_sticky", ERR_OVF, 1);

        // reset in the middle of a word
        send_n(401, 24);
        chk("mid_in_full", IN_FULL, 1);
        send_n(425, 5);
        #2;
        RST_X = 1'b0;
        #1;
        chk("mid_rst_doten", DOTEN, 0);
        chk("mid_rst_in_full", IN_FULL, 0);
        chk("mid_rst_err_ovf", ERR_OVF, 0);
        chk("mid_rst_dot", DOT, 0);
        tick();
        RST_X = 1'b1;
        send_n(501, 8);
        chk("mid_clean_doten", DOTEN, 1);
        chk("mid_clean_dot", DOT, word(501, 8));
        chk("mid_clean_cnt", DOT_CNT, 8);

`ifdef RECORD_PACKER_ORDER_CHECK_EN
        pulse_reset();
        send_n(3, 2);
        send_n(4, 1);
        chk("ord_ok", ERR_ORD, 0);
        send_n(2, 1);
        chk("ord_set", ERR_ORD, 1);
        send_n(10, 1);
        chk("ord_sticky", ERR_ORD, 1);
        pulse_reset();
        send_n(9, 1);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        send_n(1, 1);
        chk("ord_after_flush", ERR_ORD, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
